int_div_unit: RTL and testbench

Iterative RV32M integer divider for DIV, DIVU, REM and REMU, launched from the execute stage. It drives `div_unit_busy` and a one-cycle completion pulse to the hazard handler and writeback path, so a second divide cannot start while one is in flight. It also resolves the RISC-V special cases (divide by zero, signed overflow) on a fast path.

---
 rtl/int_div_unit.sv | 158 +++++++++++++++
 tb/tb_int_div_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/int_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): radix-2 restoring, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve in one cycle; flush or reset abandon work silently.
module int_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic [XLEN-1:0] div_result,
  output logic [4:0]      div_rd,
  output logic            div_done,
  output logic            div_unit_busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            is_rem_q, is_rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [4:0]      rd_work_q, rd_work_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;

  logic            signed_op;
  logic            div_by_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   part;
  logic            trial_neg;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] rem_nxt, quo_nxt;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    signed_op   = ~div_op[0];
    div_by_zero = (rs2_data == '0);
    sgn_ovf     = signed_op && (rs1_data == INT_MIN) && (rs2_data == '1);
    abs1        = (signed_op && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    abs2        = (signed_op && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;

    // The shifted partial remainder can exceed 32 bits for large unsigned divisors.
    part      = {rem_q, quo_q[XLEN-1]};
    trial_neg = (part < {1'b0, dvsr_q});
    diff      = part[XLEN-1:0] - dvsr_q;
    rem_nxt   = trial_neg ? part[XLEN-1:0] : diff;
    quo_nxt   = {quo_q[XLEN-2:0], ~trial_neg};
    quo_fix   = q_neg_q ? -quo_nxt : quo_nxt;
    rem_fix   = r_neg_q ? -rem_nxt : rem_nxt;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    is_rem_d  = is_rem_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    rd_work_d = rd_work_q;
    result_d  = result_q;
    rd_d      = rd_q;

    case (state_q)
      IDLE: begin
        if (div_start && !flush) begin
          is_rem_d  = div_op[1];
          rd_work_d = rd_in;
          q_neg_d   = signed_op & (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
          r_neg_d   = signed_op & rs1_data[XLEN-1];
          rem_d     = '0;
          quo_d     = abs1;
          dvsr_d    = abs2;
          count_d   = '0;
          if (div_by_zero) begin
            result_d = div_op[1] ? rs1_data : '1;
            rd_d     = rd_in;
            state_d  = DONE;
          end else if (sgn_ovf) begin
            result_d = div_op[1] ? '0 : INT_MIN;
            rd_d     = rd_in;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d   = rem_nxt;
          quo_d   = quo_nxt;
          count_d = count_q + CW'(1);
          if (count_q == LAST_ITER) begin
            result_d = is_rem_q ? rem_fix : quo_fix;
            rd_d     = rd_work_q;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      is_rem_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rd_work_q <= '0;
      result_q  <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      is_rem_q  <= is_rem_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      rd_work_q <= rd_work_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
    end
  end

  assign div_result    = result_q;
  assign div_rd        = rd_q;
  assign div_done      = (state_q == DONE);
  assign div_unit_busy = (state_q != IDLE);

endmodule

// File: tb/tb_int_div_unit.sv
// Directed bench for int_div_unit: hand-computed quotients/remainders, latency, flush and reset.
module tb_int_div_unit;

  logic        clk;
  logic        reset;
  logic        div_start;
  logic [1:0]  div_op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        flush;
  logic [31:0] div_result;
  logic [4:0]  div_rd;
  logic        div_done;
  logic        div_unit_busy;

  int checks   = 0;
  int failures = 0;

  int_div_unit #(.XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .div_start     (div_start),
    .div_op        (div_op),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rd_in         (rd_in),
    .flush         (flush),
    .div_result    (div_result),
    .div_rd        (div_rd),
    .div_done      (div_done),
    .div_unit_busy (div_unit_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int exp_lat);
    int lat;
    div_op = op; rs1_data = a; rs2_data = b; rd_in = rd; div_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start = 1'b0;
    chk({tag, "_busy"}, {31'd0, div_unit_busy}, 32'd1);
    lat = 0;
    while (!div_done && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, div_result, exp_res);
    chk({tag, "_rd"}, {27'd0, div_rd}, {27'd0, rd});
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, div_unit_busy, div_done}, 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    reset = 1'b0; div_start = 1'b0; div_op = 2'b00;
    rs1_data = '0; rs2_data = '0; rd_in = '0; flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_result", div_result, 32'd0);
    chk("rst_rd", {27'd0, div_rd}, 32'd0);
    chk("rst_flags", {30'd0, div_unit_busy, div_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd11, 32'd14, 32);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd12, 32'd2, 32);
    do_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd13, 32'hFFFF_FFF2, 32);
    do_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd14, 32'hFFFF_FFFE, 32);
    do_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 5'd15, 32'd2, 32);
    do_op("div_5_0", 2'b00, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, 0);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd17, 32'd5, 0);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 0);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0, 0);
    do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd20, 32'hFFFF_FFFF, 32);
    do_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 5'd21, 32'h7FFF_FFFF, 32);
    do_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 5'd22, 32'd1, 32);

    // Flush on E0+10: nothing completes and the previous result/tag survive.
    div_op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd10; rd_in = 5'd9; div_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
      if (div_done) seen = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_no_done", {31'd0, seen | div_done}, 32'd0);
    chk("flush_busy", {31'd0, div_unit_busy}, 32'd0);
    chk("flush_result", div_result, 32'd1);
    chk("flush_rd", {27'd0, div_rd}, 32'd22);
    do_op("after_flush", 2'b01, 32'd1000, 32'd10, 5'd9, 32'd100, 32);

    // In IDLE, flush wins over start.
    div_start = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", {31'd0, div_unit_busy}, 32'd0);

    // Start held during CALC with different operands must be ignored.
    div_op = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3; div_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_op = 2'b00; rs1_data = 32'd50; rs2_data = 32'd5; rd_in = 5'd4;
    lat = 0;
    while (!div_done && lat < 40) begin
      if (lat == 10) div_start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    div_start = 1'b0;
    chk("hold_lat", 32'(lat), 32'd32);
    chk("hold_res", div_result, 32'd14);
    chk("hold_rd", {27'd0, div_rd}, 32'd3);
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset mid-CALC clears outputs at once and no done follows.
    div_op = 2'b01; rs1_data = 32'd500; rs2_data = 32'd3; rd_in = 5'd7; div_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_result", div_result, 32'd0);
    chk("mid_rst_rd", {27'd0, div_rd}, 32'd0);
    chk("mid_rst_flags", {30'd0, div_unit_busy, div_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (div_done || div_unit_busy) seen = 1'b1;
    end
    chk("mid_rst_quiet", {31'd0, seen}, 32'd0);
    do_op("post_rst", 2'b11, 32'd77, 32'd10, 5'd5, 32'd7, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
